// File: rtl/mouse_bus_pkg.sv
// Shared constants and types for the mouse bus responder: register offsets,
// CTRL bit positions and the interrupt FSM state encoding.
package mouse_bus_pkg;

  localparam logic [7:0] OFS_CTRL   = 8'd0;
  localparam logic [7:0] OFS_STATUS = 8'd1;
  localparam logic [7:0] OFS_DX     = 8'd2;
  localparam logic [7:0] OFS_DY     = 8'd3;
  localparam logic [7:0] OFS_OVR    = 8'd4;
  localparam logic [7:0] NUM_REGS   = 8'd5;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_PEND   = 1;
  localparam int CTRL_OVR    = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add_s8.sv
// Combinational signed 8-bit adder that clamps to -128..+127 instead of wrapping.
module sat_add_s8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] sum_o
);

  logic [7:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    sum_o = raw;
    // Overflow only when both operands share a sign the result does not.
    if (a_i[7] == b_i[7] && raw[7] != a_i[7]) begin
      sum_o = a_i[7] ? 8'h80 : 8'h7F;
    end
  end

endmodule

// File: rtl/mouse_bus_if.sv
// Bus responder exposing mouse packets (CTRL/STATUS/DX/DY/OVR_CNT) with a level IRQ.
// Define MOUSE_ACCUM_EN to merge packets arriving while pending instead of dropping them.
module mouse_bus_if
  import mouse_bus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hA0,
  parameter logic       IRQ_EN_RESET = 1'b1
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       MOUSE_VALID,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  state_e     state_q, state_d;
  logic       irq_en_q, irq_en_d;
  logic [7:0] status_q, status_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic [7:0] ovr_q, ovr_d;
  logic       bus_oe_q, bus_oe_d;
  logic [7:0] bus_data_q, bus_data_d;

  logic [7:0] ofs;
  logic       in_win, rd_hit, wr_hit, pend, accept, lost;
  logic       unused_wdata;

  assign ofs          = BUS_ADDR - BASE_ADDR;
  assign in_win       = (ofs < NUM_REGS);
  assign rd_hit       = in_win && !BUS_WE;
  assign wr_hit       = in_win && BUS_WE;
  assign pend         = (state_q == S_PEND);
  assign accept       = MOUSE_VALID && (!pend || BUS_INTERRUPT_ACK);
  assign lost         = MOUSE_VALID && pend && !BUS_INTERRUPT_ACK;
  assign unused_wdata = ^BUS_DATA[7:1];

`ifdef MOUSE_ACCUM_EN
  logic [7:0] dx_sum, dy_sum;
  sat_add_s8 u_sat_dx (.a_i(dx_q), .b_i(MOUSE_DX), .sum_o(dx_sum));
  sat_add_s8 u_sat_dy (.a_i(dy_q), .b_i(MOUSE_DY), .sum_o(dy_sum));
`endif

  always_comb begin
    irq_en_d   = irq_en_q;
    status_d   = status_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    ovr_d      = ovr_q;
    bus_oe_d   = rd_hit;
    bus_data_d = 8'h00;

    if (wr_hit && ofs == OFS_CTRL) irq_en_d = BUS_DATA[CTRL_IRQ_EN];

    if (accept) begin
      status_d = MOUSE_STATUS;
      dx_d     = MOUSE_DX;
      dy_d     = MOUSE_DY;
    end
`ifdef MOUSE_ACCUM_EN
    else if (lost) begin
      status_d = MOUSE_STATUS;
      dx_d     = dx_sum;
      dy_d     = dy_sum;
    end
`endif

    // A clear write beats a same-cycle overrun increment.
    if (wr_hit && ofs == OFS_OVR)       ovr_d = 8'h00;
    else if (lost && ovr_q != 8'hFF)    ovr_d = ovr_q + 8'd1;

    // Read data reflects register values held before this edge.
    if (rd_hit) begin
      case (ofs)
        OFS_CTRL: begin
          bus_data_d[CTRL_IRQ_EN] = irq_en_q;
          bus_data_d[CTRL_PEND]   = pend;
          bus_data_d[CTRL_OVR]    = (ovr_q != 8'h00);
        end
        OFS_STATUS: bus_data_d = status_q;
        OFS_DX:     bus_data_d = dx_q;
        OFS_DY:     bus_data_d = dy_q;
        OFS_OVR:    bus_data_d = ovr_q;
        default:    bus_data_d = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (MOUSE_VALID && irq_en_d) state_d = S_PEND;
      S_PEND: if (!irq_en_d || (BUS_INTERRUPT_ACK && !MOUSE_VALID)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUS_INTERRUPT_RAISE = (state_q == S_PEND);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q   <= IRQ_EN_RESET;
      status_q   <= 8'h00;
      dx_q       <= 8'h00;
      dy_q       <= 8'h00;
      ovr_q      <= 8'h00;
      bus_oe_q   <= 1'b0;
      bus_data_q <= 8'h00;
    end else begin
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      ovr_q      <= ovr_d;
      bus_oe_q   <= bus_oe_d;
      bus_data_q <= bus_data_d;
    end
  end

  assign BUS_DATA = bus_oe_q ? bus_data_q : 8'hzz;

endmodule

// File: tb/tb_mouse_bus_if.sv
// Self-checking bench for mouse_bus_if: directed scenarios plus randomized traffic
// compared against a register-level behavioural model.
module tb_mouse_bus_if;

  localparam logic [7:0] BASE = 8'hA0;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  wire  [7:0] bus_data;
  logic [7:0] drv_val = 8'h00;
  logic       drv_en  = 1'b0;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_we = 1'b0;
  logic [7:0] m_status_in = 8'h00, m_dx_in = 8'h00, m_dy_in = 8'h00;
  logic       m_valid = 1'b0;
  logic       irq_raise;
  logic       irq_ack = 1'b0;

  assign bus_data = drv_en ? drv_val : 8'hzz;

  mouse_bus_if #(.BASE_ADDR(BASE), .IRQ_EN_RESET(1'b1)) dut (
    .clk_sys            (clk_sys),
    .rst_n              (rst_n),
    .BUS_DATA           (bus_data),
    .BUS_ADDR           (bus_addr),
    .BUS_WE             (bus_we),
    .MOUSE_STATUS       (m_status_in),
    .MOUSE_DX           (m_dx_in),
    .MOUSE_DY           (m_dy_in),
    .MOUSE_VALID        (m_valid),
    .BUS_INTERRUPT_RAISE(irq_raise),
    .BUS_INTERRUPT_ACK  (irq_ack)
  );

  always #10 clk_sys = ~clk_sys;

  // Whether the responder is currently driving the shared bus.
  wire bus_driven = dut.bus_oe_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: the architectural register file and pending flag.
  bit       md_en;
  bit       md_pend;
  bit [7:0] md_status, md_dx, md_dy, md_ovr;

  task automatic model_reset();
    md_en = 1'b1; md_pend = 1'b0;
    md_status = 8'h00; md_dx = 8'h00; md_dy = 8'h00; md_ovr = 8'h00;
  endtask

  function automatic bit [7:0] clamp_s8(input int v);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic bit [7:0] model_read(input bit [7:0] o);
    case (o)
      8'd0:    return {5'b0, md_ovr != 0, md_pend, md_en};
      8'd1:    return md_status;
      8'd2:    return md_dx;
      8'd3:    return md_dy;
      8'd4:    return md_ovr;
      default: return 8'h00;
    endcase
  endfunction

  // One bus cycle: apply inputs, clock, update model, check outputs #1 after the edge.
  task automatic cycle(input bit [7:0] addr, input bit we, input bit [7:0] wd,
                       input bit valid, input bit [7:0] st, input bit [7:0] dx,
                       input bit [7:0] dy, input bit ack);
    bit [7:0] o;
    bit       in_win, exp_oe, new_en, lost;
    bit [7:0] exp_data;
    bus_addr = addr; bus_we = we; drv_val = wd; drv_en = we;
    m_valid = valid; m_status_in = st; m_dx_in = dx; m_dy_in = dy; irq_ack = ack;
    @(posedge clk_sys);
    o        = addr - BASE;
    in_win   = (o < 5);
    exp_oe   = in_win && !we;
    exp_data = model_read(o);
    new_en   = (we && in_win && o == 0) ? wd[0] : md_en;
    lost     = valid && md_pend && !ack;
    if (valid && (!md_pend || ack)) begin
      md_status = st; md_dx = dx; md_dy = dy;
    end
`ifdef MOUSE_ACCUM_EN
    else if (lost) begin
      md_status = st;
      md_dx = clamp_s8(int'($signed(md_dx)) + int'($signed(dx)));
      md_dy = clamp_s8(int'($signed(md_dy)) + int'($signed(dy)));
    end
`endif
    if (we && in_win && o == 4) md_ovr = 8'h00;
    else if (lost && md_ovr < 8'hFF) md_ovr = md_ovr + 8'd1;
    if (!md_pend) md_pend = valid && new_en;
    else          md_pend = new_en && !(ack && !valid);
    md_en = new_en;
    #1;
    bus_we = 1'b0; drv_en = 1'b0; m_valid = 1'b0; irq_ack = 1'b0; bus_addr = 8'h00;
    check("raise", irq_raise, md_pend);
    check("bus_oe", bus_driven, exp_oe);
    if (exp_oe) begin
      check("rd_data", bus_data, exp_data);
      $display("rd  addr=%02h data=%02h", addr, bus_data);
    end
  endtask

  task automatic idle();
    cycle(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
  endtask

  task automatic rd(input bit [7:0] addr, input bit [7:0] lit);
    cycle(addr, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    check("rd_lit", bus_data, lit);
  endtask

  task automatic wr(input bit [7:0] addr, input bit [7:0] wd);
    cycle(addr, 1, wd, 0, 8'h00, 8'h00, 8'h00, 0);
    $display("wr  addr=%02h data=%02h", addr, wd);
  endtask

  task automatic pkt(input bit [7:0] st, input bit [7:0] dx, input bit [7:0] dy, input bit ack);
    cycle(8'h00, 0, 8'h00, 1, st, dx, dy, ack);
    $display("pkt st=%02h dx=%02h dy=%02h ack=%0d raise=%0d", st, dx, dy, ack, irq_raise);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    check("rst_raise", irq_raise, 1'b0);
    check("rst_oe", bus_driven, 1'b0);

    rd(BASE + 8'd0, 8'h01);
    idle();
    pkt(8'h09, 8'h05, 8'hFB, 0);
    check("raise_after_valid", irq_raise, 1'b1);
    rd(BASE + 8'd1, 8'h09);
    rd(BASE + 8'd2, 8'h05);
    rd(BASE + 8'd3, 8'hFB);
    pkt(8'h00, 8'h00, 8'h00, 0);
    cycle(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
    check("raise_after_ack", irq_raise, 1'b0);

    pkt(8'h09, 8'h05, 8'hFB, 0);
    pkt(8'h08, 8'h22, 8'h22, 0);
    pkt(8'h08, 8'h23, 8'h23, 0);
    rd(BASE + 8'd4, 8'h03);
    rd(BASE + 8'd0, 8'h07);
    wr(BASE + 8'd4, 8'h55);
    rd(BASE + 8'd4, 8'h00);
    cycle(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);

    wr(BASE + 8'd0, 8'h00);
    pkt(8'h01, 8'h33, 8'h44, 0);
    check("raise_masked", irq_raise, 1'b0);
    rd(BASE + 8'd2, 8'h33);
    cycle(8'h9F, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    check("out_of_window", bus_driven, 1'b0);

    wr(BASE + 8'd0, 8'h01);
    pkt(8'h02, 8'h11, 8'h11, 0);
    pkt(8'h03, 8'h44, 8'h45, 1);
    check("valid_ack_raise", irq_raise, 1'b1);
    rd(BASE + 8'd4, 8'h00);
    rd(BASE + 8'd2, 8'h44);
    rst_n = 1'b0;
    #1;
    check("rst_mid_read_oe", bus_driven, 1'b0);
    check("rst_mid_read_raise", irq_raise, 1'b0);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    rd(BASE + 8'd2, 8'h00);

`ifdef MOUSE_ACCUM_EN
    pkt(8'h01, 8'h70, 8'h90, 0);
    pkt(8'h02, 8'h30, 8'hC0, 0);
    rd(BASE + 8'd2, 8'h7F);
    rd(BASE + 8'd3, 8'h80);
    rd(BASE + 8'd1, 8'h02);
    cycle(8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
`endif

    for (int i = 0; i < 500; i++) begin
      bit [7:0] a, wd;
      bit       we;
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 5));
      we = ($urandom_range(0, 5) == 0);
      wd = 8'($urandom);
      if (we && a == BASE && $urandom_range(0, 4) != 0) wd[0] = 1'b1;
      cycle(a, we, wd, $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom),
            8'($urandom), $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
